downcount: RTL and testbench

DOWNCOUNT -- requirements
Module: downcount

---
 rtl/downcount_pkg.sv | 10 +
 rtl/downcount.sv | 82 ++++++++
 tb/tb_downcount.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/downcount_pkg.sv
// Shared types for the downcount block: FSM state encoding only.
package downcount_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/downcount.sv
// Loadable modulo-N down counter with IDLE/RUN/DONE sequencing.
// Optional feature macro: DOWNCOUNT_AUTORELOAD_EN -- when defined, reaching
// zero in RUN reloads N-1 and keeps running; DONE is never entered.
import downcount_pkg::*;

module downcount #(
  parameter int N = 13,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         sreset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_enable,
  output logic [W-1:0] o_val,
  output logic         o_last,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [W-1:0] MAXV = W'(N - 1);

  state_t       state, state_nxt;
  logic [W-1:0] val, val_nxt;
  logic [W-1:0] load_clamped;

  // Loads above the modulus saturate to the top count.
  assign load_clamped = (i_load_val > MAXV) ? MAXV : i_load_val;

  // State and count registers; reset beats every other input on the edge.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state <= IDLE;
      val   <= MAXV;
    end else begin
      state <= state_nxt;
      val   <= val_nxt;
    end
  end

  // Next-state and next-count: load first, then per-state enable handling.
  always_comb begin
    state_nxt = state;
    val_nxt   = val;
    if (i_load) begin
      state_nxt = IDLE;
      val_nxt   = load_clamped;
    end else begin
      case (state)
        IDLE: if (i_enable) state_nxt = RUN;
        RUN: begin
          if (i_enable) begin
            if (val != '0) begin
              val_nxt = val - W'(1);
            end else begin
`ifdef DOWNCOUNT_AUTORELOAD_EN
              val_nxt = MAXV;
`else
              state_nxt = DONE;
`endif
            end
          end
        end
        DONE: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status outputs decoded purely from registered state and count.
  always_comb begin
    o_val  = val;
    o_busy = (state == RUN);
    o_last = (state == RUN) && (val == '0);
`ifdef DOWNCOUNT_AUTORELOAD_EN
    o_done = 1'b0;
`else
    o_done = (state == DONE);
`endif
  end

endmodule

// File: tb/tb_downcount.sv
// Directed self-checking bench for downcount at N = 13.
module tb_downcount;

  localparam int N = 13;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         sreset = 1'b1;
  logic         i_load = 1'b0;
  logic [W-1:0] i_load_val = '0;
  logic         i_enable = 1'b0;
  logic [W-1:0] o_val;
  logic         o_last, o_busy, o_done;

  int n_pass = 0;
  int n_total = 0;

  downcount #(.N(N)) dut (
    .clk(clk), .sreset(sreset), .i_load(i_load), .i_load_val(i_load_val),
    .i_enable(i_enable), .o_val(o_val), .o_last(o_last), .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full output snapshot against expected val/last/busy/done.
  task automatic chk_all(input string tag, input int v, input int l,
                         input int b, input int d);
    chk({tag, ".val"},  int'(o_val),  v);
    chk({tag, ".last"}, int'(o_last), l);
    chk({tag, ".busy"}, int'(o_busy), b);
    chk({tag, ".done"}, int'(o_done), d);
  endtask

  initial begin
    // Reset
    step();
    chk_all("reset", 12, 0, 0, 0);

    // Full run with enable held from reset
    sreset = 1'b0; i_enable = 1'b1;
    step();
    chk_all("run_e1", 12, 0, 1, 0);
    step(11);
    chk_all("run_e12", 1, 0, 1, 0);
    step();
    chk_all("run_e13", 0, 1, 1, 0);
    step();
`ifdef DOWNCOUNT_AUTORELOAD_EN
    chk_all("run_e14_reload", 12, 0, 1, 0);
`else
    chk_all("run_e14_done", 0, 0, 0, 1);
    // DONE ignores enable
    step(2);
    chk_all("done_hold", 0, 0, 0, 1);
`endif

    // Load leaves any state for IDLE
    i_enable = 1'b0; i_load = 1'b1; i_load_val = 4'd2;
    step();
    chk_all("load2", 2, 0, 0, 0);

    // Clamp boundaries
    i_load_val = 4'd15;
    step();
    chk("clamp15", int'(o_val), 12);
    i_load_val = 4'd13;
    step();
    chk("clamp13", int'(o_val), 12);
    i_load_val = 4'd12;
    step();
    chk("load12", int'(o_val), 12);
    i_load_val = 4'd0;
    step();
    chk_all("load0", 0, 0, 0, 0);

    // IDLE with enable low holds
    i_load = 1'b0;
    step(2);
    chk_all("idle_hold", 0, 0, 0, 0);

    // Start at 12, decrement twice, then load 5 with enable still high
    i_load = 1'b1; i_load_val = 4'd12;
    step();
    i_load = 1'b0; i_enable = 1'b1;
    step(3);
    chk_all("pre_load5", 10, 0, 1, 0);
    i_load = 1'b1; i_load_val = 4'd5;
    step();
    chk_all("load5_midrun", 5, 0, 0, 0);
    i_load = 1'b0;
    step();
    chk_all("v5_e1", 5, 0, 1, 0);
    step(5);
    chk_all("v5_e6", 0, 1, 1, 0);
    step();
`ifdef DOWNCOUNT_AUTORELOAD_EN
    chk_all("v5_e7_reload", 12, 0, 1, 0);
`else
    chk_all("v5_e7_done", 0, 0, 0, 1);
`endif

    // Pause at 8
    i_load = 1'b1; i_load_val = 4'd10; i_enable = 1'b0;
    step();
    i_load = 1'b0; i_enable = 1'b1;
    step(3);
    chk("at8", int'(o_val), 8);
    i_enable = 1'b0;
    step(3);
    chk_all("pause8", 8, 0, 1, 0);
    i_enable = 1'b1;
    step();
    chk_all("resume7", 7, 0, 1, 0);

    // Pause at zero keeps o_last asserted
    step(7);
    i_enable = 1'b0;
    step(2);
    chk_all("pause0", 0, 1, 1, 0);

    // Reset mid-run with load and enable also high
    i_load = 1'b1; i_load_val = 4'd8;
    step();
    i_load = 1'b0; i_enable = 1'b1;
    step(3);
    chk_all("at6", 6, 0, 1, 0);
    sreset = 1'b1; i_load = 1'b1; i_load_val = 4'd3;
    step();
    chk_all("reset_prio", 12, 0, 0, 0);
    sreset = 1'b0; i_load = 1'b0; i_enable = 1'b0;
    step();
    chk_all("post_reset_idle", 12, 0, 0, 0);

`ifdef DOWNCOUNT_AUTORELOAD_EN
    // Long enabled run: never DONE, always wraps to 12
    i_enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      chk("ar_nodone", int'(o_done), 0);
      chk("ar_busy", int'(o_busy), 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
